// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a 2-entry skid buffer, stall/bubble control and
// saturating stall/bubble event counters.
module pipe_stage_elastic #(
  parameter int                 DATA_W     = 143,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = {2'h0, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF},
  parameter int                 CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall,
  input  logic              bubble,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic              push, pop;

  // in_ready depends only on control inputs and local state, never on out_ready.
  assign in_ready   = !rst && !stall && !bubble && (state_q != TWO);
  assign out_valid  = (state_q != EMPTY);
  assign out_data   = main_q;
  assign occupancy  = state_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready && !stall && !bubble;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bubble) begin
      state_d = ONE;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else if (!stall) begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
          end
        end
        TWO: begin
          // skid always holds the younger entry, so it moves up on pop
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall && !bubble && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (bubble && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_q       <= BUBBLE_VAL;
      skid_q       <= BUBBLE_VAL;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule
